// File: rtl/m_data_mem.sv
// rtl/m_data_mem.sv - M-stage word data memory with byte-enable stores, wait states and post-reset clear sweep
module m_data_mem #(
  parameter int DEPTH_WORDS = 3072,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        M_Req,
  input  logic        M_MemWrite,
  input  logic [1:0]  M_StoreType,
  input  logic [31:0] M_StoreAddr,
  input  logic [31:0] M_WriteData,
  output logic [31:0] M_MemoryData,
  output logic        M_Stall,
  output logic        M_AddrErr
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]    state;
  logic [AW-1:0] initIdx;
  logic [CW-1:0] waitCnt;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [29:0]   wordAddr;
  logic [AW-1:0] wordIdx;
  logic          outOfRange;
  logic          misaligned;
  logic          addrBad;
  logic          validReq;
  logic          dataValid;
  logic          memWe;
  logic [3:0]    byteEn;
  logic [31:0]   storeData;

  assign wordAddr = M_StoreAddr[31:2];
  assign wordIdx  = wordAddr[AW-1:0];

  // Range check uses the full word address so high address bits cannot alias into the array.
  assign outOfRange = {2'b00, wordAddr} >= 32'(DEPTH_WORDS);

  always_comb begin
    misaligned = 1'b0;
    case (M_StoreType)
      2'b01:   misaligned = M_StoreAddr[0];
      2'b10:   misaligned = 1'b0;
      default: misaligned = (M_StoreAddr[1:0] != 2'b00);
    endcase
  end

  assign addrBad   = outOfRange || misaligned;
  assign validReq  = M_Req && !addrBad && (state != ST_INIT);
  assign M_AddrErr = M_Req && addrBad && (state != ST_INIT);
  assign dataValid = validReq && ((state == ST_IDLE) || (state == ST_DONE));

  always_comb begin
    byteEn    = 4'b1111;
    storeData = M_WriteData;
    case (M_StoreType)
      2'b01: begin
        byteEn    = M_StoreAddr[1] ? 4'b1100 : 4'b0011;
        storeData = {M_WriteData[15:0], M_WriteData[15:0]};
      end
      2'b10: begin
        byteEn    = 4'b0001 << M_StoreAddr[1:0];
        storeData = {4{M_WriteData[7:0]}};
      end
      default: begin
        byteEn    = 4'b1111;
        storeData = M_WriteData;
      end
    endcase
  end

  // Zero-latency builds commit in the request cycle; otherwise only at the end of DONE.
  always_comb begin
    memWe = 1'b0;
    if (validReq && M_MemWrite) begin
      if (WAIT_CYCLES == 0) memWe = (state == ST_IDLE);
      else                  memWe = (state == ST_DONE);
    end
  end

  always_comb begin
    M_Stall = 1'b1;
    case (state)
      ST_INIT: M_Stall = 1'b1;
      ST_IDLE: M_Stall = (WAIT_CYCLES > 0) && validReq;
      ST_WAIT: M_Stall = 1'b1;
      ST_DONE: M_Stall = 1'b0;
      default: M_Stall = 1'b1;
    endcase
  end

  assign M_MemoryData = dataValid ? mem[wordIdx] : 32'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_INIT;
      initIdx <= '0;
      waitCnt <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          initIdx <= initIdx + 1'b1;
          if (initIdx == AW'(DEPTH_WORDS - 1)) begin
            state   <= ST_IDLE;
            initIdx <= '0;
          end
        end
        ST_IDLE: begin
          if ((WAIT_CYCLES > 0) && validReq) begin
            if (WAIT_CYCLES == 1) begin
              state <= ST_DONE;
            end else begin
              state   <= ST_WAIT;
              waitCnt <= CW'(WAIT_CYCLES - 1);
            end
          end
        end
        ST_WAIT: begin
          waitCnt <= waitCnt - 1'b1;
          if (waitCnt == CW'(1)) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_INIT;
      endcase
    end
  end

  // The array has no reset; the INIT sweep clears it one word per cycle.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[initIdx] <= 32'h0;
    end else if (memWe) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) mem[wordIdx][8*b +: 8] <= storeData[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_m_data_mem.sv
// tb/tb_m_data_mem.sv - directed and randomized checks of m_data_mem across four wait/depth configurations
module tb_m_data_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn     [4];
  logic        req      [4];
  logic        memWrite [4];
  logic [1:0]  sType    [4];
  logic [31:0] sAddr    [4];
  logic [31:0] wData    [4];
  logic [31:0] mData    [4];
  logic        stall    [4];
  logic        aErr     [4];

  int total = 0;
  int bad   = 0;

  m_data_mem #(.DEPTH_WORDS(8), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(rstn[0]), .M_Req(req[0]), .M_MemWrite(memWrite[0]),
    .M_StoreType(sType[0]), .M_StoreAddr(sAddr[0]), .M_WriteData(wData[0]),
    .M_MemoryData(mData[0]), .M_Stall(stall[0]), .M_AddrErr(aErr[0]));

  m_data_mem #(.DEPTH_WORDS(64), .WAIT_CYCLES(1)) u1 (
    .clk(clk), .reset(rstn[1]), .M_Req(req[1]), .M_MemWrite(memWrite[1]),
    .M_StoreType(sType[1]), .M_StoreAddr(sAddr[1]), .M_WriteData(wData[1]),
    .M_MemoryData(mData[1]), .M_Stall(stall[1]), .M_AddrErr(aErr[1]));

  m_data_mem #(.DEPTH_WORDS(16), .WAIT_CYCLES(2)) u2 (
    .clk(clk), .reset(rstn[2]), .M_Req(req[2]), .M_MemWrite(memWrite[2]),
    .M_StoreType(sType[2]), .M_StoreAddr(sAddr[2]), .M_WriteData(wData[2]),
    .M_MemoryData(mData[2]), .M_Stall(stall[2]), .M_AddrErr(aErr[2]));

  m_data_mem #(.DEPTH_WORDS(16), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .reset(rstn[3]), .M_Req(req[3]), .M_MemWrite(memWrite[3]),
    .M_StoreType(sType[3]), .M_StoreAddr(sAddr[3]), .M_WriteData(wData[3]),
    .M_MemoryData(mData[3]), .M_Stall(stall[3]), .M_AddrErr(aErr[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Holds a request until the stall drops, returning the sampled outputs of the final cycle.
  task automatic doAccess(input int k, input logic wr, input logic [1:0] ty, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int stalls);
    bit done;
    done = 1'b0;
    req[k] = 1'b1; memWrite[k] = wr; sType[k] = ty; sAddr[k] = a; wData[k] = wd;
    stalls = 0; rd = 'x; er = 1'bx;
    for (int c = 0; c < 16 && !done; c++) begin
      @(negedge clk);
      if (stall[k] === 1'b1) stalls++;
      else begin
        rd = mData[k]; er = aErr[k]; done = 1'b1;
      end
      @(posedge clk); #1;
    end
    req[k] = 1'b0;
    check("access_done", {31'b0, done}, 32'd1);
  endtask

  task automatic expectAccess(input string tag, input int k, input logic wr, input logic [1:0] ty,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] expData,
                              input logic expErr, input int expStalls);
    logic [31:0] rd;
    logic        er;
    int          st;
    doAccess(k, wr, ty, a, wd, rd, er, st);
    check({tag, "_data"}, rd, expData);
    check({tag, "_err"}, {31'b0, er}, {31'b0, expErr});
    check({tag, "_stalls"}, 32'(st), 32'(expStalls));
  endtask

  task automatic countInit(input string tag, input int k, input int expLen);
    int n;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (stall[k] === 1'b1) n++;
      else break;
    end
    check(tag, 32'(n), 32'(expLen));
    @(posedge clk); #1;
  endtask

  logic [7:0]  mb [256];
  logic [31:0] a, wd, rd, expWord;
  logic [1:0]  ty;
  logic        wr, er, expErr;
  int          st, base;

  initial begin
    for (int k = 0; k < 4; k++) begin
      rstn[k] = 1'b0; req[k] = 1'b0; memWrite[k] = 1'b0;
      sType[k] = 2'b00; sAddr[k] = 32'h0; wData[k] = 32'h0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_stall%0d", k), {31'b0, stall[k]}, 32'd1);
      check($sformatf("rst_data%0d", k), mData[k], 32'h0);
      check($sformatf("rst_err%0d", k), {31'b0, aErr[k]}, 32'd0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) rstn[k] = 1'b1;

    countInit("u0_init_len", 0, 8);
    expectAccess("u0_ld1c", 0, 1'b0, 2'b00, 32'h1C, 32'h0, 32'h0, 1'b0, 0);
    expectAccess("u0_sw4", 0, 1'b1, 2'b00, 32'h4, 32'h12345678, 32'h0, 1'b0, 0);
    expectAccess("u0_sh6", 0, 1'b1, 2'b01, 32'h6, 32'h0000BEEF, 32'h12345678, 1'b0, 0);
    expectAccess("u0_sb4", 0, 1'b1, 2'b10, 32'h4, 32'h000000AA, 32'hBEEF5678, 1'b0, 0);
    expectAccess("u0_lw4", 0, 1'b0, 2'b00, 32'h4, 32'h0, 32'hBEEF56AA, 1'b0, 0);
    expectAccess("u0_oor", 0, 1'b0, 2'b00, 32'h20, 32'h0, 32'h0, 1'b1, 0);

    repeat (70) @(posedge clk);
    @(negedge clk);
    for (int k = 1; k < 4; k++) check($sformatf("post_init_stall%0d", k), {31'b0, stall[k]}, 32'd0);
    @(posedge clk); #1;

    expectAccess("u2_sw8", 2, 1'b1, 2'b00, 32'h8, 32'hCAFEF00D, 32'h0, 1'b0, 2);
    expectAccess("u2_lw8", 2, 1'b0, 2'b00, 32'h8, 32'h0, 32'hCAFEF00D, 1'b0, 2);
    expectAccess("u2_sw2", 2, 1'b1, 2'b00, 32'h2, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
    expectAccess("u2_sh5", 2, 1'b1, 2'b01, 32'h5, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
    expectAccess("u2_swoor", 2, 1'b1, 2'b00, 32'h40, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
    expectAccess("u2_swalias", 2, 1'b1, 2'b00, 32'h80000008, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
    expectAccess("u2_rb0", 2, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 2);
    expectAccess("u2_rb4", 2, 1'b0, 2'b00, 32'h4, 32'h0, 32'h0, 1'b0, 2);
    expectAccess("u2_rb8", 2, 1'b0, 2'b00, 32'h8, 32'h0, 32'hCAFEF00D, 1'b0, 2);

    expectAccess("u3_sw14", 3, 1'b1, 2'b00, 32'h14, 32'h55555555, 32'h0, 1'b0, 3);
    expectAccess("u3_lw14", 3, 1'b0, 2'b00, 32'h14, 32'h0, 32'h55555555, 1'b0, 3);
    req[3] = 1'b1; memWrite[3] = 1'b1; sType[3] = 2'b00; sAddr[3] = 32'h0; wData[3] = 32'hFFFFFFFF;
    @(posedge clk); @(posedge clk); #3;
    rstn[3] = 1'b0;
    #1;
    check("u3_midrst_stall", {31'b0, stall[3]}, 32'd1);
    check("u3_midrst_data", mData[3], 32'h0);
    req[3] = 1'b0; memWrite[3] = 1'b0;
    @(posedge clk); #1;
    rstn[3] = 1'b1;
    countInit("u3_reinit_len", 3, 16);
    expectAccess("u3_lw0", 3, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 3);
    expectAccess("u3_lw14_clr", 3, 1'b0, 2'b00, 32'h14, 32'h0, 32'h0, 1'b0, 3);

    // Byte-array reference: little-endian bytes, memory cleared by the INIT sweep.
    for (int i = 0; i < 256; i++) mb[i] = 8'h00;
    for (int i = 0; i < 500; i++) begin
      wr = 1'($urandom_range(0, 1));
      ty = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 271));
      if ($urandom_range(0, 15) == 0) a = a | 32'h80000000;
      wd = $urandom;
      expErr = (a / 4 >= 64) || (ty == 2'd1 && a % 2 != 0) ||
               ((ty == 2'd0 || ty == 2'd3) && a % 4 != 0);
      expWord = 32'h0;
      base = 0;
      if (!expErr) begin
        base = int'(a) & ~3;
        expWord = {mb[base+3], mb[base+2], mb[base+1], mb[base]};
      end
      doAccess(1, wr, ty, a, wd, rd, er, st);
      check($sformatf("rnd%0d_err", i), {31'b0, er}, {31'b0, expErr});
      check($sformatf("rnd%0d_stalls", i), 32'(st), expErr ? 32'd0 : 32'd1);
      check($sformatf("rnd%0d_data", i), rd, expWord);
      if (!expErr && wr) begin
        case (ty)
          2'd1: begin
            mb[int'(a)]     = wd[7:0];
            mb[int'(a) + 1] = wd[15:8];
          end
          2'd2: mb[int'(a)] = wd[7:0];
          default: for (int b = 0; b < 4; b++) mb[base + b] = wd[8*b +: 8];
        endcase
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/m_data_mem.md
# m_data_mem

Word-organised data memory for the M stage. Accepts one load or store per instruction from the E/M pipeline register and generates byte enables for `sw`/`sh`/`sb`. Returns the raw aligned 32-bit word to the M-stage load-data extender, which handles sub-word selection and sign/zero extension. Supports configurable wait states with a pipeline stall output, and clears its own contents after reset with a sweep counter.

## Interface
Parameters:
- `DEPTH_WORDS`, 3072: number of 32-bit words; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
- `WAIT_CYCLES`, 1: extra cycles per access; 0 means a single-cycle access.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `M_Req`  in  1  the M-stage instruction accesses memory (load or store).
- `M_MemWrite`  in  1  1 = store, 0 = load; ignored when `M_Req`=0.
- `M_StoreType`  in  2  00 word, 01 half, 10 byte; 11 is treated as word. Also used for the alignment check on loads.
- `M_StoreAddr`  in  32  byte address of the access.
- `M_WriteData`  in  32  raw rt value; only the low 16 or 8 bits are used for half or byte stores.
- `M_MemoryData`  out  32  raw word at `M_StoreAddr[31:2]`, sent to the extender.
- `M_Stall`  out  1  freeze F/D/E/M; all inputs are held stable while this is 1.
- `M_AddrErr`  out  1  access is misaligned or out of range; no write occurs.

## Operation
- FSM states: INIT, IDLE, WAIT, DONE.
- INIT (entered on reset):
  - Writes 0 to word `init_idx` each cycle, with `init_idx` counting 0 .. DEPTH_WORDS-1.
  - Moves to IDLE after the last word is written.
  - `M_Stall`=1 throughout; requests are ignored.
- Address error (combinational, from current inputs):
  - Word access with `addr[1:0]`≠0.
  - Half access with `addr[0]`≠0.
  - `addr[31:2]` ≥ DEPTH_WORDS.
- When `M_Req`=1 and `M_AddrErr`=1:
  - No stall, no write, `M_MemoryData`=0.
  - The FSM stays in IDLE.
- Byte enables and write data:
  - Word: BE=1111, data = `M_WriteData`.
  - Half: BE = `addr[1]` ? 1100 : 0011, data = {wd[15:0], wd[15:0]}.
  - Byte: BE = 0001 << `addr[1:0]`, data = wd[7:0] replicated 4 times.
  - Bytes with BE=0 are left unchanged.
- WAIT_CYCLES=0:
  - IDLE only; `M_Stall`=0.
  - Loads: `M_MemoryData` is read combinationally from the array.
  - Stores: committed at the rising edge ending the request cycle.
- WAIT_CYCLES=N>0:
  - IDLE with a valid `M_Req`: `M_Stall`=1 combinationally; load counter with N-1; go to WAIT.
  - WAIT: `M_Stall`=1; decrement the counter; at 0, go to DONE.
  - DONE: `M_Stall`=0, `M_MemoryData` valid; a store commits at the edge ending DONE; return to IDLE.
- `M_MemoryData` is 0 whenever no valid access is being served, i.e. in INIT, in WAIT, or in IDLE with `M_Req`=0.
- Width rules:
  - The word index is `addr[31:2]`, compared against DEPTH_WORDS at full width (no truncation aliasing).
  - The counter is wide enough for WAIT_CYCLES.

## Timing
- Values at reset (asynchronous, immediate):
  - State=INIT, `init_idx`=0, counter=0.
  - `M_Stall`=1, `M_MemoryData`=0, `M_AddrErr`=0.
- After reset release, INIT lasts exactly DEPTH_WORDS cycles; `M_Stall` first drops in the following cycle.
- Access latency:
  - WAIT_CYCLES=0: 1 cycle.
  - WAIT_CYCLES=N: N+1 cycles, made up of the IDLE request cycle, N-1 WAIT cycles, and the DONE cycle.
  - Stall is asserted in the first N of these cycles.
- Back-to-back accesses: the next request is seen in IDLE the cycle after DONE. There is no dead cycle between accesses.
- Reset asserted mid-WAIT or mid-DONE: the pending store is discarded and the array is re-cleared from word 0.
- Read-after-write to the same word: a later access observes the committed write. Forwarding into the same cycle is not required.

## Test plan
- Reset then release, DEPTH_WORDS=8, WAIT_CYCLES=0 -> `M_Stall`=1 for exactly 8 cycles, then 0; a load at 0x1C returns 0.
- WAIT_CYCLES=0: `sw` 0x12345678 @0x4, then `sh` 0xBEEF @0x6, then `sb` 0xAA @0x4 -> a word load @0x4 returns 0xBEEF56AA.
- WAIT_CYCLES=2: store request held -> stall pattern 1,1,0; the write is visible to the next load; that load's stall pattern is 1,1,0 and it returns the stored word.
- Misaligned `sw` @0x2, `sh` @0x5, and access @4*DEPTH_WORDS -> `M_AddrErr`=1, `M_Stall`=0, memory unchanged on read-back.
- WAIT_CYCLES=3: assert `reset` during WAIT of a `sw` 0xFFFFFFFF @0x0 -> after INIT, a load @0x0 returns 0.
- Random mix of 500 load/store operations against a byte-array model with WAIT_CYCLES=1 -> every `M_MemoryData` in DONE matches the model.
